// File: rtl/pixel_mac16_if.sv
// Pixel/coefficient input stream and result output stream of pixel_mac16.
// The slave modport is the MAC stage; the master modport is whoever feeds it and drains it.
interface pixel_mac16_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  pixel_in;
  logic [7:0]  coeff_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result16;
  logic        sat;

  modport slave (
    input  in_valid, pixel_in, coeff_in, out_ready,
    output in_ready, out_valid, result16, sat
  );

  modport master (
    output in_valid, pixel_in, coeff_in, out_ready,
    input  in_ready, out_valid, result16, sat
  );
endinterface

// File: rtl/pixel_mac16.sv
// Windowed MAC stage: accumulates TAPS pixel*coefficient products, then shifts and saturates
// the sum into one 16-bit unsigned result per window.
module pixel_mac16 #(
  parameter int unsigned TAPS  = 9,
  parameter int unsigned SHIFT = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  pixel_mac16_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACC, FIN, OUT} state_t;

  state_t             state;
  state_t             state_next;
  logic [3:0]         count;
  logic signed [20:0] acc;
  logic signed [20:0] acc_shift;
  logic signed [16:0] pixel_ext;
  logic signed [16:0] coeff_ext;
  logic signed [16:0] product;
  logic signed [20:0] product_ext;
  logic [15:0]        result_q;
  logic [15:0]        result_d;
  logic               sat_q;
  logic               sat_d;
  logic               ready;
  logic               valid;
  logic               accept;
  logic               last_beat;

  // Pixel is unsigned, so it is zero-extended; the 17-bit product cannot overflow.
  assign pixel_ext   = {9'd0, bus.pixel_in};
  assign coeff_ext   = {{9{bus.coeff_in[7]}}, bus.coeff_in};
  assign product     = pixel_ext * coeff_ext;
  assign product_ext = {{4{product[16]}}, product};

  assign accept    = bus.in_valid && ready;
  assign last_beat = (({1'b0, count} + 5'd1) == 5'(TAPS));
  assign acc_shift = acc >>> SHIFT;

  always_comb begin
    result_d = acc_shift[15:0];
    sat_d    = 1'b0;
    if (acc_shift[20]) begin
      result_d = 16'd0;
      sat_d    = 1'b1;
    end else if (|acc_shift[19:16]) begin
      result_d = 16'hFFFF;
      sat_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // clear overrides every other transition, including an in-flight acceptance.
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    valid      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (bus.in_valid) state_next = last_beat ? FIN : ACC;
      end
      ACC: begin
        ready = 1'b1;
        if (bus.in_valid && last_beat) state_next = FIN;
      end
      FIN: state_next = OUT;
      OUT: begin
        valid = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (clear) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= 4'd0;
      acc      <= 21'sd0;
      result_q <= 16'd0;
      sat_q    <= 1'b0;
    end else if (clear) begin
      count <= 4'd0;
      acc   <= 21'sd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc   <= product_ext;
            count <= 4'd1;
          end
        end
        ACC: begin
          if (accept) begin
            acc   <= acc + product_ext;
            count <= count + 4'd1;
          end
        end
        FIN: begin
          result_q <= result_d;
          sat_q    <= sat_d;
        end
        OUT: begin
          if (bus.out_ready) count <= 4'd0;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = valid;
  assign bus.result16  = result_q;
  assign bus.sat       = sat_q;

endmodule

// File: tb/tb_pixel_mac16.sv
// Directed bench for pixel_mac16: three instances (TAPS/SHIFT = 9/0, 9/4, 1/0) share clk, rst_n and clear.
module tb_pixel_mac16;

  logic clk = 1'b0;
  logic rst_n;
  logic clear;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  pixel_mac16_if if0 ();
  pixel_mac16_if if4 ();
  pixel_mac16_if if1 ();

  pixel_mac16 #(.TAPS(9), .SHIFT(0)) dut0 (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(if0));
  pixel_mac16 #(.TAPS(9), .SHIFT(4)) dut4 (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(if4));
  pixel_mac16 #(.TAPS(1), .SHIFT(0)) dut1 (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(if1));

  // mask bit 0 -> if0, bit 1 -> if4, bit 2 -> if1
  task automatic drive(input logic [2:0] mask, input logic v, input logic [7:0] p, input logic [7:0] c);
    if (mask[0]) begin if0.in_valid = v; if0.pixel_in = p; if0.coeff_in = c; end
    if (mask[1]) begin if4.in_valid = v; if4.pixel_in = p; if4.coeff_in = c; end
    if (mask[2]) begin if1.in_valid = v; if1.pixel_in = p; if1.coeff_in = c; end
  endtask

  // Returns at the falling edge right after the last beat was taken (the FIN cycle).
  task automatic send_beats(input logic [2:0] mask, input int n, input logic [7:0] p, input logic [7:0] c);
    repeat (n) begin
      @(negedge clk);
      drive(mask, 1'b1, p, c);
    end
    @(negedge clk);
    drive(mask, 1'b0, 8'd0, 8'd0);
  endtask

  task automatic test_reset;
    vectors++; if (if0.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", if0.in_ready); end
    vectors++; if (if0.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", if0.out_valid); end
    vectors++; if (if0.result16 !== 16'd0) begin miscompares++; $display("FAIL reset_result got %0d want 0", if0.result16); end
    vectors++; if (if0.sat !== 1'b0) begin miscompares++; $display("FAIL reset_sat got %b want 0", if0.sat); end
  endtask

  task automatic test_basic;
    send_beats(3'b001, 9, 8'd10, 8'h01);
    vectors++; if (if0.out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_fin_valid got %b want 0", if0.out_valid); end
    vectors++; if (if0.in_ready !== 1'b0) begin miscompares++; $display("FAIL basic_fin_ready got %b want 0", if0.in_ready); end
    @(negedge clk);
    vectors++; if (if0.out_valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid got %b want 1", if0.out_valid); end
    vectors++; if (if0.result16 !== 16'd90) begin miscompares++; $display("FAIL basic_result got %0d want 90", if0.result16); end
    vectors++; if (if0.sat !== 1'b0) begin miscompares++; $display("FAIL basic_sat got %b want 0", if0.sat); end
    @(negedge clk);
    vectors++; if (if0.out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_valid_pulse got %b want 0", if0.out_valid); end
    vectors++; if (if0.in_ready !== 1'b1) begin miscompares++; $display("FAIL basic_ready_after got %b want 1", if0.in_ready); end
  endtask

  task automatic test_shift_sat;
    send_beats(3'b011, 9, 8'd255, 8'd127);
    @(negedge clk);
    vectors++; if (if4.out_valid !== 1'b1) begin miscompares++; $display("FAIL shift4_valid got %b want 1", if4.out_valid); end
    vectors++; if (if4.result16 !== 16'd18216) begin miscompares++; $display("FAIL shift4_result got %0d want 18216", if4.result16); end
    vectors++; if (if4.sat !== 1'b0) begin miscompares++; $display("FAIL shift4_sat got %b want 0", if4.sat); end
    vectors++; if (if0.result16 !== 16'd65535) begin miscompares++; $display("FAIL hisat_result got %0d want 65535", if0.result16); end
    vectors++; if (if0.sat !== 1'b1) begin miscompares++; $display("FAIL hisat_sat got %b want 1", if0.sat); end
    @(negedge clk);
  endtask

  task automatic test_negative;
    send_beats(3'b001, 9, 8'd200, 8'hFF);
    @(negedge clk);
    vectors++; if (if0.result16 !== 16'd0) begin miscompares++; $display("FAIL neg_result got %0d want 0", if0.result16); end
    vectors++; if (if0.sat !== 1'b1) begin miscompares++; $display("FAIL neg_sat got %b want 1", if0.sat); end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    if0.out_ready = 1'b0;
    send_beats(3'b001, 9, 8'd3, 8'd5);
    drive(3'b001, 1'b1, 8'd50, 8'd9);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++; if (if0.out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid[%0d] got %b want 1", i, if0.out_valid); end
      vectors++; if (if0.result16 !== 16'd135) begin miscompares++; $display("FAIL bp_result[%0d] got %0d want 135", i, if0.result16); end
      vectors++; if (if0.in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready[%0d] got %b want 0", i, if0.in_ready); end
    end
    if0.out_ready = 1'b1;
    drive(3'b001, 1'b0, 8'd0, 8'd0);
    @(negedge clk);
    vectors++; if (if0.out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_consumed got %b want 0", if0.out_valid); end
    vectors++; if (if0.in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_ready_after got %b want 1", if0.in_ready); end
    send_beats(3'b001, 9, 8'd1, 8'd1);
    @(negedge clk);
    vectors++; if (if0.result16 !== 16'd9) begin miscompares++; $display("FAIL bp_no_extra_beat got %0d want 9", if0.result16); end
    @(negedge clk);
  endtask

  task automatic test_abort_clear;
    repeat (4) begin
      @(negedge clk);
      drive(3'b001, 1'b1, 8'd7, 8'd3);
    end
    @(negedge clk);
    drive(3'b001, 1'b1, 8'd7, 8'd3);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    drive(3'b001, 1'b0, 8'd0, 8'd0);
    vectors++; if (if0.in_ready !== 1'b1) begin miscompares++; $display("FAIL clr_idle got %b want 1", if0.in_ready); end
    vectors++; if (if0.out_valid !== 1'b0) begin miscompares++; $display("FAIL clr_valid got %b want 0", if0.out_valid); end
    send_beats(3'b001, 9, 8'd1, 8'd2);
    @(negedge clk);
    vectors++; if (if0.out_valid !== 1'b1) begin miscompares++; $display("FAIL clr_next_valid got %b want 1", if0.out_valid); end
    vectors++; if (if0.result16 !== 16'd18) begin miscompares++; $display("FAIL clr_next_result got %0d want 18", if0.result16); end
    @(negedge clk);
  endtask

  task automatic test_abort_reset;
    repeat (4) begin
      @(negedge clk);
      drive(3'b001, 1'b1, 8'd7, 8'd3);
    end
    @(negedge clk);
    drive(3'b001, 1'b1, 8'd7, 8'd3);
    rst_n = 1'b0;
    #1;
    vectors++; if (if0.in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready got %b want 1", if0.in_ready); end
    vectors++; if (if0.out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %b want 0", if0.out_valid); end
    vectors++; if (if0.result16 !== 16'd0) begin miscompares++; $display("FAIL rst_result got %0d want 0", if0.result16); end
    vectors++; if (if4.result16 !== 16'd0) begin miscompares++; $display("FAIL rst_result4 got %0d want 0", if4.result16); end
    vectors++; if (if0.sat !== 1'b0) begin miscompares++; $display("FAIL rst_sat got %b want 0", if0.sat); end
    @(negedge clk);
    rst_n = 1'b1;
    drive(3'b001, 1'b0, 8'd0, 8'd0);
    send_beats(3'b001, 9, 8'd1, 8'd2);
    @(negedge clk);
    vectors++; if (if0.result16 !== 16'd18) begin miscompares++; $display("FAIL rst_next_result got %0d want 18", if0.result16); end
    @(negedge clk);
  endtask

  task automatic test_taps1;
    send_beats(3'b100, 1, 8'd100, 8'd3);
    vectors++; if (if1.out_valid !== 1'b0) begin miscompares++; $display("FAIL t1_fin_valid got %b want 0", if1.out_valid); end
    @(negedge clk);
    vectors++; if (if1.out_valid !== 1'b1) begin miscompares++; $display("FAIL t1_valid got %b want 1", if1.out_valid); end
    vectors++; if (if1.result16 !== 16'd300) begin miscompares++; $display("FAIL t1_result got %0d want 300", if1.result16); end
    @(negedge clk);
    vectors++; if (if1.in_ready !== 1'b1) begin miscompares++; $display("FAIL t1_ready_after got %b want 1", if1.in_ready); end
  endtask

  // Windows every TAPS+2 = 3 cycles with no idle gap in between.
  task automatic test_back_to_back;
    logic [7:0]  pix [2];
    logic [15:0] want [2];
    pix[0] = 8'd5; want[0] = 16'd35;
    pix[1] = 8'd2; want[1] = 16'd14;
    @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      vectors++; if (if1.in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready[%0d] got %b want 1", w, if1.in_ready); end
      drive(3'b100, 1'b1, pix[w], 8'd7);
      @(negedge clk);
      drive(3'b100, 1'b0, 8'd0, 8'd0);
      @(negedge clk);
      vectors++; if (if1.out_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid[%0d] got %b want 1", w, if1.out_valid); end
      vectors++; if (if1.result16 !== want[w]) begin miscompares++; $display("FAIL b2b_result[%0d] got %0d want %0d", w, if1.result16, want[w]); end
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clear = 1'b0;
    drive(3'b111, 1'b0, 8'd0, 8'd0);
    if0.out_ready = 1'b1;
    if4.out_ready = 1'b1;
    if1.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_basic();
    test_shift_sat();
    test_negative();
    test_backpressure();
    test_abort_clear();
    test_abort_reset();
    test_taps1();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pixel_mac16.md
# pixel_mac16

Windowed multiply-accumulate stage for the image-processing datapath. It accepts a stream of 8-bit unsigned pixels paired with 8-bit signed kernel coefficients, accumulates `TAPS` products, and applies an arithmetic right shift plus saturation. It then presents one 16-bit unsigned result per window. The result bus feeds the 16-to-8-bit narrowing stage directly downstream, which keeps bits [7:0].

## Interface
- `TAPS`, 9, number of pixel/coefficient pairs per window; legal range 1..16.
- `SHIFT`, 0, arithmetic right shift applied to the accumulator before saturation; legal range 0..15.

- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `clear` input 1: synchronous abort; discards any partial window.
- `in_valid` input 1: pixel/coefficient pair present.
- `in_ready` output 1: stage can accept a pair.
- `pixel_in` input 8: unsigned pixel.
- `coeff_in` input 8: two's-complement coefficient.
- `out_valid` output 1: result available.
- `out_ready` input 1: downstream accepts the result.
- `result16` output 16: saturated unsigned result.
- `sat` output 1: the result was clamped; valid with `out_valid`.

## Operation
- States are IDLE, ACC, FIN and OUT. The tap counter is 4 bits wide; the accumulator is 21-bit signed.
- A beat is accepted when `in_valid && in_ready`.
- `in_ready` = 1 in IDLE and ACC, and 0 in FIN and OUT.
- Product = zero-extended `pixel_in` (9-bit signed) × sign-extended `coeff_in`, giving a 17-bit signed value. The product is sign-extended to 21 bits before it is added.
- IDLE:
  - An accepted beat loads acc = product and count = 1.
  - If TAPS = 1, the next state is FIN; otherwise it is ACC.
- ACC:
  - An accepted beat sets acc += product and count += 1.
  - When the accepted beat is the TAPS-th beat, the next state is FIN.
  - Cycles without an accepted beat hold all state.
- FIN (exactly one cycle):
  - s = acc >>> SHIFT (arithmetic shift).
  - If s < 0: `result16` = 0 and `sat` = 1.
  - Else if s > 65535: `result16` = 65535 and `sat` = 1.
  - Otherwise: `result16` = s[15:0] and `sat` = 0.
  - The result is registered. The next state is OUT.
- OUT:
  - `out_valid` = 1.
  - `result16` and `sat` are held stable until `out_valid && out_ready`.
  - On acceptance the next state is IDLE and count = 0.
- Worst-case magnitude: 16 × 255 × 128 = 522240, which fits in 21-bit signed. The accumulator can never wrap.
- `clear`:
  - Forces IDLE, sets count = 0 and acc = 0, and deasserts `out_valid`.
  - `clear` has priority over any beat or acceptance in the same cycle. Such a beat is dropped.
  - A result in OUT that has not been accepted is discarded.
- Reset mid-operation has the same effect as `clear`, applied asynchronously.

## Timing
- Reset values: `in_ready` = 1 (IDLE), `out_valid` = 0, `result16` = 0, `sat` = 0, count = 0, acc = 0, state = IDLE.
- The last beat is accepted at edge k. FIN is entered after edge k, and `out_valid` is high after edge k+1. Latency is 2 cycles from the last beat to a valid result.
- Minimum window period is TAPS + 2 cycles, provided `out_ready` is held high.
- If `out_ready` is high in the first OUT cycle, `out_valid` is high for exactly one cycle. `in_ready` is high on the following cycle.
- Back-to-back beats are accepted every cycle in IDLE and ACC. There is no bubble between beats.
- `in_ready` does not depend combinationally on `out_ready`. The window after the current one starts only after OUT is exited.

## Test plan
- TAPS=9, SHIFT=0; nine beats of pixel 10, coeff 1 (0x01), sent back-to-back with `out_ready` = 1. Required: `out_valid` 2 cycles after the 9th beat, `result16` = 90, `sat` = 0, and `in_ready` high on the cycle after `out_valid`.
- TAPS=9, SHIFT=4; nine beats of pixel 255, coeff 127. Required: acc = 291465, `result16` = 18216 (0x4728), `sat` = 0. The same stimulus with SHIFT=0 must give `result16` = 65535 and `sat` = 1.
- TAPS=9, SHIFT=0; nine beats of pixel 200, coeff 0xFF (−1). Required: acc = −1800, `result16` = 0, `sat` = 1.
- Backpressure: complete one window with `out_ready` held low for 5 cycles, driving `in_valid` = 1 throughout. Required: `out_valid` stays high and `result16` stays stable, `in_ready` = 0, and no beat is accepted. When `out_ready` rises, the result is consumed in one cycle.
- Abort:
  - Accept 4 beats, then pulse `clear` in the same cycle as a 5th valid beat. Required: that beat is dropped, the block returns to IDLE, and the next 9 beats of pixel 1, coeff 2 give `result16` = 18.
  - Repeat the sequence with `rst_n` asserted low instead of `clear`. Required: all outputs take their reset values immediately.
- TAPS=1, SHIFT=0; a single beat of pixel 100, coeff 3. Required: `result16` = 300, with `out_valid` high 2 cycles after the beat.
